// File: rtl/ucount_capture_pkg.sv
// rtl/ucount_capture_pkg.sv - shared widths and capture-record type for ucount_capture
package ucount_capture_pkg;

  localparam int CNT_W           = 16;
  localparam int EPOCH_W_DEFAULT = 8;

  typedef struct packed {
    logic [EPOCH_W_DEFAULT-1:0] epoch;
    logic [CNT_W-1:0]           count;
  } cap_rec_t;

endpackage

// File: rtl/ucap_fifo.sv
// rtl/ucap_fifo.sv - show-ahead synchronous FIFO with level, full/empty and drop indication
module ucap_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          drop_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a coincident push.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & full_o & ~do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/ucount_capture.sv
// rtl/ucount_capture.sv - compare/capture timer peripheral built on a free-running 16-bit counter
module ucount_capture
  import ucount_capture_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int EPOCH_W    = EPOCH_W_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CNT_W-1:0]              dcount_15,
  input  logic                          overflow,
  input  logic [CNT_W-1:0]              cmp_val,
  input  logic                          cmp_load,
  input  logic                          cmp_en,
  input  logic                          cap_trig,
  input  logic                          rd_en,
  input  logic                          clr_lost,
  output logic                          match,
  output logic [EPOCH_W-1:0]            epoch,
  output logic [EPOCH_W+CNT_W-1:0]      cap_data,
  output logic                          cap_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          cap_lost
);

  logic               ovf_q, trig_q, eq_q;
  logic               match_q, match_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [CNT_W-1:0]   cmp_q, cmp_d;
  logic               lost_q, lost_d;
  logic               ovf_rise, trig_rise, eq;
  logic               fifo_full, fifo_empty, fifo_drop;

  assign ovf_rise  = overflow & ~ovf_q;
  assign trig_rise = cap_trig & ~trig_q;
  assign eq        = cmp_en & (dcount_15 == cmp_q);

  always_comb begin
    epoch_d = epoch_q + EPOCH_W'(ovf_rise);
    cmp_d   = cmp_load ? cmp_val : cmp_q;
    match_d = eq & ~eq_q;
    lost_d  = lost_q;
    // A drop in the same cycle as clr_lost must not be lost, so set wins.
    if (clr_lost)  lost_d = 1'b0;
    if (fifo_drop) lost_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q   <= 1'b0;
      trig_q  <= 1'b0;
      eq_q    <= 1'b0;
      match_q <= 1'b0;
      epoch_q <= '0;
      cmp_q   <= '0;
      lost_q  <= 1'b0;
    end else begin
      ovf_q   <= overflow;
      trig_q  <= cap_trig;
      eq_q    <= eq;
      match_q <= match_d;
      epoch_q <= epoch_d;
      cmp_q   <= cmp_d;
      lost_q  <= lost_d;
    end
  end

  // The record carries the pre-increment epoch when an overflow edge coincides.
  ucap_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EPOCH_W + CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (trig_rise),
    .pop_i   (rd_en),
    .wdata_i ({epoch_q, dcount_15}),
    .rdata_o (cap_data),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  assign match     = match_q;
  assign epoch     = epoch_q;
  assign cap_valid = ~fifo_empty;
  assign cap_lost  = lost_q;

endmodule
